// File: rtl/sdp_bram_arbiter.sv
// Two-requester arbiter in front of a simple-dual-port BRAM with 1-cycle read latency.
// Independent round-robin on read and write ports; same-address reads yield to writes.
module sdp_bram_arbiter #(
   parameter int unsigned ABITS = 10,
   parameter int unsigned DBITS = 36
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           rd_req,
   input  logic [2*ABITS-1:0]   rd_addr,
   output logic [1:0]           rd_gnt,
   output logic [1:0]           rsp_vld,
   output logic [DBITS-1:0]     rsp_data,
   input  logic [1:0]           wr_req,
   input  logic [2*ABITS-1:0]   wr_addr,
   input  logic [2*DBITS-1:0]   wr_data,
   output logic [1:0]           wr_gnt,
   output logic [ABITS-1:0]     ram_ra,
   input  logic [DBITS-1:0]     ram_rd,
   output logic [ABITS-1:0]     ram_wa,
   output logic [DBITS-1:0]     ram_wd,
   output logic                 ram_we
);

   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       rsp_vld_q, rsp_vld_d;

   logic             wr_any, wr_sel;
   logic             rd_any, rd_sel, rd_go;
   logic [ABITS-1:0] wr_sel_addr, rd_sel_addr;
   logic [DBITS-1:0] wr_sel_data;

   always_comb begin
      // Gating with rst_n keeps all grants and the write enable low during reset.
      wr_any      = rst_n & (|wr_req);
      wr_sel      = (wr_req == 2'b11) ? wr_ptr_q : wr_req[1];
      wr_sel_addr = wr_sel ? wr_addr[2*ABITS-1:ABITS] : wr_addr[ABITS-1:0];
      wr_sel_data = wr_sel ? wr_data[2*DBITS-1:DBITS] : wr_data[DBITS-1:0];

      rd_any      = rst_n & (|rd_req);
      rd_sel      = (rd_req == 2'b11) ? rd_ptr_q : rd_req[1];
      rd_sel_addr = rd_sel ? rd_addr[2*ABITS-1:ABITS] : rd_addr[ABITS-1:0];
      // A read colliding with this cycle's write retries so it returns the new data.
      rd_go       = rd_any & ~(wr_any & (rd_sel_addr == wr_sel_addr));

      wr_gnt    = 2'b00;
      ram_we    = 1'b0;
      ram_wa    = '0;
      ram_wd    = '0;
      wr_ptr_d  = wr_ptr_q;
      if (wr_any) begin
         wr_gnt[wr_sel] = 1'b1;
         ram_we         = 1'b1;
         ram_wa         = wr_sel_addr;
         ram_wd         = wr_sel_data;
         wr_ptr_d       = ~wr_sel;
      end

      rd_gnt    = 2'b00;
      ram_ra    = '0;
      rsp_vld_d = 2'b00;
      rd_ptr_d  = rd_ptr_q;
      if (rd_go) begin
         rd_gnt[rd_sel]    = 1'b1;
         ram_ra            = rd_sel_addr;
         rsp_vld_d[rd_sel] = 1'b1;
         rd_ptr_d          = ~rd_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         rsp_vld_q <= 2'b00;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         rsp_vld_q <= rsp_vld_d;
      end
   end

   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = ram_rd;

endmodule

// File: tb/tb_sdp_bram_arbiter.sv
// Directed and randomized bench for sdp_bram_arbiter with a behavioural BRAM and a
// reference model of arbitration, collision stalls and read responses.
module tb_sdp_bram_arbiter;

   localparam int unsigned ABITS = 10;
   localparam int unsigned DBITS = 36;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           rd_req, wr_req;
   logic [ABITS-1:0]     ra [2];
   logic [ABITS-1:0]     wa [2];
   logic [DBITS-1:0]     wd [2];
   logic [2*ABITS-1:0]   rd_addr, wr_addr;
   logic [2*DBITS-1:0]   wr_data;
   logic [1:0]           rd_gnt, wr_gnt, rsp_vld;
   logic [DBITS-1:0]     rsp_data, ram_rd, ram_wd;
   logic [ABITS-1:0]     ram_ra, ram_wa;
   logic                 ram_we;

   assign rd_addr = {ra[1], ra[0]};
   assign wr_addr = {wa[1], wa[0]};
   assign wr_data = {wd[1], wd[0]};

   always #5 clk = ~clk;

   sdp_bram_arbiter #(.ABITS(ABITS), .DBITS(DBITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_gnt   (rd_gnt),
      .rsp_vld  (rsp_vld),
      .rsp_data (rsp_data),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_gnt   (wr_gnt),
      .ram_ra   (ram_ra),
      .ram_rd   (ram_rd),
      .ram_wa   (ram_wa),
      .ram_wd   (ram_wd),
      .ram_we   (ram_we)
   );

   // Behavioural SDP BRAM, 1-cycle read latency.
   logic [DBITS-1:0] mem [2**ABITS];
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_wd;
      ram_rd <= mem[ram_ra];
   end

   // Reference model state.
   int               total = 0;
   int               bad   = 0;
   int               rprio = 0, wprio = 0;
   logic [DBITS-1:0] ref_mem [int];
   bit               pend_vld = 0;
   int               pend_id  = 0;
   logic [DBITS-1:0] pend_data;
   logic [1:0]       eg_r = 2'b00, eg_w = 2'b00;
   logic [1:0]       obs_rg, obs_wg, obs_rv;
   logic [DBITS-1:0] obs_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DBITS-1:0] ref_rd(input logic [ABITS-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return 'x;
   endfunction

   task automatic step();
      bit               wv, rv;
      int               w, r;
      logic [ABITS-1:0] ewa, era;
      logic [DBITS-1:0] ewd;
      @(negedge clk);
      obs_rg   = rd_gnt;
      obs_wg   = wr_gnt;
      obs_rv   = rsp_vld;
      obs_data = rsp_data;
      if (!rst_n) begin
         chk("rst_rd_gnt", rd_gnt, 0);
         chk("rst_wr_gnt", wr_gnt, 0);
         chk("rst_rsp_vld", rsp_vld, 0);
         chk("rst_ram_we", ram_we, 0);
         rprio = 0; wprio = 0; pend_vld = 0; eg_r = 0; eg_w = 0;
      end else begin
         wv  = (wr_req != 0);
         w   = (wr_req == 2'b11) ? wprio : (wr_req[1] ? 1 : 0);
         ewa = wv ? wa[w] : '0;
         ewd = wv ? wd[w] : '0;
         rv  = (rd_req != 0);
         r   = (rd_req == 2'b11) ? rprio : (rd_req[1] ? 1 : 0);
         if (rv && wv && ra[r] == ewa) rv = 0;
         era = rv ? ra[r] : '0;
         eg_w = wv ? 2'(1 << w) : 2'b00;
         eg_r = rv ? 2'(1 << r) : 2'b00;
         chk("wr_gnt", wr_gnt, eg_w);
         chk("ram_we", ram_we, wv);
         chk("ram_wa", ram_wa, ewa);
         chk("ram_wd", ram_wd, ewd);
         chk("rd_gnt", rd_gnt, eg_r);
         chk("ram_ra", ram_ra, era);
         chk("rsp_vld", rsp_vld, pend_vld ? 2'(1 << pend_id) : 2'b00);
         if (pend_vld) chk("rsp_data", rsp_data, pend_data);
         pend_vld = rv;
         pend_id  = r;
         if (rv) begin
            pend_data = ref_rd(ra[r]);
            rprio     = 1 - r;
         end
         if (wv) begin
            ref_mem[int'(ewa)] = ewd;
            wprio              = 1 - w;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_req = 2'b00;
      wr_req = 2'b00;
   endtask

   initial begin
      rst_n  = 1'b0;
      rd_req = 2'b11; wr_req = 2'b11;
      ra[0] = 1; ra[1] = 2; wa[0] = 5; wa[1] = 6;
      wd[0] = 36'h1; wd[1] = 36'h2;

      // 1: reset with all requests high, then req0 wins first on both ports.
      step(); step();
      rst_n = 1'b1;
      step();
      chk("t1_first_rd", obs_rg, 2'b01);
      chk("t1_first_wr", obs_wg, 2'b01);
      step();
      chk("t1_second_rd", obs_rg, 2'b10);
      idle();

      for (int i = 0; i < 16; i++) begin
         wr_req = 2'b01; wa[0] = ABITS'(i); wd[0] = DBITS'($urandom);
         step();
      end
      idle();

      // 2: tied reads alternate.
      rd_req = 2'b11; ra[0] = 5; ra[1] = 9;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t2_alt", obs_rg, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      idle();
      step();

      // 3: write then read the same address.
      wr_req = 2'b01; wa[0] = 3; wd[0] = 36'hABC;
      step();
      wr_req = 2'b00; rd_req = 2'b10; ra[1] = 3;
      step();
      idle();
      step();
      chk("t3_vld", obs_rv, 2'b10);
      chk("t3_data", obs_data, 36'hABC);

      // 4: same-cycle collision stalls the read.
      wr_req = 2'b01; wa[0] = 7; wd[0] = 36'h55; rd_req = 2'b10; ra[1] = 7;
      step();
      chk("t4_wg", obs_wg, 2'b01);
      chk("t4_rg_stall", obs_rg, 2'b00);
      wr_req = 2'b00;
      step();
      chk("t4_rg_retry", obs_rg, 2'b10);
      idle();
      step();
      chk("t4_data", obs_data, 36'h55);

      // Requester 1 writes alone so requester 0 has write priority for test 5.
      wr_req = 2'b10; wa[1] = 100; wd[1] = 36'h7;
      step();

      // 5: both write addr 2; last grant persists.
      wr_req = 2'b11; wa[0] = 2; wa[1] = 2; wd[0] = 36'h11; wd[1] = 36'h22;
      step();
      chk("t5_first", obs_wg, 2'b01);
      wr_req = 2'b10;
      step();
      chk("t5_second", obs_wg, 2'b10);
      wr_req = 2'b00; rd_req = 2'b01; ra[0] = 2;
      step();
      idle();
      step();
      chk("t5_data", obs_data, 36'h22);

      // 6: reset right after a read grant discards the response.
      rd_req = 2'b01; ra[0] = 4;
      step();
      chk("t6_granted", obs_rg, 2'b01);
      rst_n = 1'b0;
      idle();
      step(); step();
      rst_n = 1'b1;
      step();
      chk("t6_no_rsp", obs_rv, 2'b00);
      rd_req = 2'b11; wr_req = 2'b11; ra[0] = 8; ra[1] = 9; wa[0] = 10; wa[1] = 11;
      step();
      chk("t6_rd_tie", obs_rg, 2'b01);
      chk("t6_wr_tie", obs_wg, 2'b01);
      idle();
      step();

      // Randomized traffic over a small address window to provoke collisions.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!rd_req[i] || eg_r[i]) begin
               rd_req[i] = 1'($urandom_range(0, 1));
               ra[i]     = ABITS'($urandom_range(0, 15));
            end
            if (!wr_req[i] || eg_w[i]) begin
               wr_req[i] = 1'($urandom_range(0, 1));
               wa[i]     = ABITS'($urandom_range(0, 15));
               wd[i]     = {4'($urandom), 32'($urandom)};
            end
         end
         step();
      end
      idle();
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
